// File: rtl/pdm_pkg.sv
// -----------------------------------------------------------------------------
// pdm_pkg
// Shared definitions for the PDM microphone decimator:
//   - CIC filter order and the number of filter outputs discarded at start-up
//   - capture state enumeration
//   - helpers deriving the CIC accumulator width and the output scaling shift
// -----------------------------------------------------------------------------
package pdm_pkg;

  localparam int CIC_ORDER      = 3;
  localparam int WARMUP_SAMPLES = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_t;

  // Register growth of an order-N CIC is N*log2(R); two extra bits keep the
  // full-scale result +2^(N*log2 R) representable as a positive number.
  function automatic int cic_acc_width(input int decimation);
    return CIC_ORDER * $clog2(decimation) + 2;
  endfunction

  // Right shift that maps the CIC gain onto a WORD_LENGTH-bit signed word.
  function automatic int cic_scale_shift(input int decimation, input int word_length);
    return CIC_ORDER * $clog2(decimation) - (word_length - 1);
  endfunction

endpackage

// File: rtl/pdm_clock_gen.sv
// -----------------------------------------------------------------------------
// pdm_clock_gen
// Divides the system clock down to the PDM microphone clock and flags the
// cycle in which that clock rises (the point where a new PDM bit is taken).
//
// Parameters:
//   PDM_DIVIDE  system clocks per pdm_clk_o period (even, >= 4)
// Ports:
//   clock_i    in   system clock, rising edge
//   reset_i    in   asynchronous active-low reset
//   enable_i   in   divider runs while high; cleared to count 0 while low
//   pdm_clk_o  out  registered PDM clock, high for count >= PDM_DIVIDE/2
//   rise_o     out  registered strobe, high in the cycle count becomes PDM_DIVIDE/2
// -----------------------------------------------------------------------------
module pdm_clock_gen #(
  parameter int PDM_DIVIDE = 50
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic enable_i,
  output logic pdm_clk_o,
  output logic rise_o
);

  localparam int CW = $clog2(PDM_DIVIDE);
  localparam logic [CW-1:0] LAST = CW'(PDM_DIVIDE - 1);
  localparam logic [CW-1:0] HALF = CW'(PDM_DIVIDE / 2);

  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;

  // Next divider count, wrapping after PDM_DIVIDE-1.
  always_comb begin
    count_next_s = count_r;
    if (count_r == LAST) begin
      count_next_s = '0;
    end else begin
      count_next_s = count_r + CW'(1);
    end
  end

  // Divider register; the clock and strobe are derived from the next count so
  // they change in the same cycle as the count they describe.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      count_r   <= '0;
      pdm_clk_o <= 1'b0;
      rise_o    <= 1'b0;
    end else if (!enable_i) begin
      count_r   <= '0;
      pdm_clk_o <= 1'b0;
      rise_o    <= 1'b0;
    end else begin
      count_r   <= count_next_s;
      pdm_clk_o <= (count_next_s >= HALF);
      rise_o    <= (count_next_s == HALF);
    end
  end

endmodule

// File: rtl/pdm_decimator.sv
// -----------------------------------------------------------------------------
// pdm_decimator
// PDM microphone front end: generates the microphone clock, synchronizes the
// 1-bit PDM stream and decimates it with a 3rd-order CIC filter into signed
// WORD_LENGTH-bit PCM samples, each announced by a one-cycle done_o strobe.
//
// Build option: define PDM_DC_BLOCK_EN to insert a first-order DC blocker
// between scaling and saturation (one extra clock of latency).
//
// Parameters:
//   WORD_LENGTH  PCM output width (signed)
//   PDM_DIVIDE   system clocks per pdm_clk_o period
//   DECIMATION   PDM bits per PCM sample (power of two)
//   DC_SHIFT     DC-blocker pole shift (PDM_DC_BLOCK_EN builds only)
// Ports:
//   clock_i     in   system clock
//   reset_i     in   asynchronous active-low reset
//   enable_i    in   capture enable (level)
//   pdm_data_i  in   raw PDM data, asynchronous to clock_i
//   pdm_clk_o   out  PDM microphone clock
//   data_o      out  latest PCM sample, held between strobes
//   done_o      out  one-cycle pulse when data_o updates
// -----------------------------------------------------------------------------
module pdm_decimator
  import pdm_pkg::*;
#(
  parameter int WORD_LENGTH = 16,
  parameter int PDM_DIVIDE  = 50,
  parameter int DECIMATION  = 64,
  parameter int DC_SHIFT    = 8
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic                   pdm_data_i,
  output logic                   pdm_clk_o,
  output logic [WORD_LENGTH-1:0] data_o,
  output logic                   done_o
);

  localparam int ACC_W  = cic_acc_width(DECIMATION);
  localparam int SHIFT  = cic_scale_shift(DECIMATION, WORD_LENGTH);
  localparam int DCNT_W = $clog2(DECIMATION);
  localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (WORD_LENGTH - 1)) - 64'sd1;
  localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (WORD_LENGTH - 1));
  localparam logic [1:0] WARM_LAST = 2'(WARMUP_SAMPLES - 1);

  if (PDM_DIVIDE < 4 || (PDM_DIVIDE % 2) != 0 || DECIMATION < 2 || DC_SHIFT < 1) begin : g_bad_params
    $error("pdm_decimator: illegal parameter combination");
  end

  // Clamp a wide signed value to the WORD_LENGTH-bit two's-complement range.
  function automatic logic [WORD_LENGTH-1:0] sat_word(input logic signed [63:0] v);
    logic [WORD_LENGTH-1:0] r;
    if (v > SAT_MAX) begin
      r = SAT_MAX[WORD_LENGTH-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[WORD_LENGTH-1:0];
    end else begin
      r = v[WORD_LENGTH-1:0];
    end
    return r;
  endfunction

  logic              rise_s;
  logic [1:0]        sync_r;
  logic [DCNT_W-1:0] sample_cnt_r;
  logic              window_end_s;

  logic signed [ACC_W-1:0] x_s;
  logic signed [ACC_W-1:0] int1_r, int2_r, int3_r;
  logic signed [ACC_W-1:0] int1_next_s, int2_next_s, int3_next_s;
  logic signed [ACC_W-1:0] dly1_r, dly2_r, dly3_r;
  logic signed [ACC_W-1:0] c1_s, c2_s, c3_s;
  logic signed [ACC_W-1:0] comb_r;
  logic                    comb_valid_r;
  logic signed [ACC_W-1:0] scaled_s;

  logic [WORD_LENGTH-1:0] out_value_s;
  logic                   out_valid_s;
  logic                   emit_s;

  state_t     state_r, state_next_s;
  logic [1:0] warm_cnt_r, warm_cnt_next_s;

  pdm_clock_gen #(
    .PDM_DIVIDE (PDM_DIVIDE)
  ) u_clock_gen (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .enable_i  (enable_i),
    .pdm_clk_o (pdm_clk_o),
    .rise_o    (rise_s)
  );

  // Two-flop synchronizer for the asynchronous PDM data.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], pdm_data_i};
    end
  end

  // Integrator cascade uses each stage's updated value so the whole filter has
  // no extra delay; the comb differences are taken on the decimated stream.
  always_comb begin
    x_s          = sync_r[1] ? ACC_W'(1) : {ACC_W{1'b1}};
    int1_next_s  = int1_r + x_s;
    int2_next_s  = int2_r + int1_next_s;
    int3_next_s  = int3_r + int2_next_s;
    c1_s         = int3_next_s - dly1_r;
    c2_s         = c1_s - dly2_r;
    c3_s         = c2_s - dly3_r;
    window_end_s = rise_s && (sample_cnt_r == {DCNT_W{1'b1}});
    scaled_s     = comb_r >>> SHIFT;
  end

  // CIC state: integrators per PDM bit, comb stage once per window; all of it
  // is discarded whenever capture is disabled.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      sample_cnt_r <= '0;
      int1_r       <= '0;
      int2_r       <= '0;
      int3_r       <= '0;
      dly1_r       <= '0;
      dly2_r       <= '0;
      dly3_r       <= '0;
      comb_r       <= '0;
      comb_valid_r <= 1'b0;
    end else if (!enable_i) begin
      sample_cnt_r <= '0;
      int1_r       <= '0;
      int2_r       <= '0;
      int3_r       <= '0;
      dly1_r       <= '0;
      dly2_r       <= '0;
      dly3_r       <= '0;
      comb_r       <= '0;
      comb_valid_r <= 1'b0;
    end else begin
      if (rise_s) begin
        sample_cnt_r <= sample_cnt_r + DCNT_W'(1);
        int1_r       <= int1_next_s;
        int2_r       <= int2_next_s;
        int3_r       <= int3_next_s;
      end
      comb_valid_r <= window_end_s;
      if (window_end_s) begin
        dly1_r <= int3_next_s;
        dly2_r <= c1_s;
        dly3_r <= c2_s;
        comb_r <= c3_s;
      end
    end
  end

`ifdef PDM_DC_BLOCK_EN
  // The blocker carries DC_SHIFT fraction bits so its decay continues below
  // one output LSB; three guard bits absorb full-scale steps.
  localparam int DC_W = WORD_LENGTH + DC_SHIFT + 3;

  logic signed [DC_W-1:0] dc_x_s, dc_z_next_s;
  logic signed [DC_W-1:0] dc_xprev_r, dc_z_r;
  logic                   dc_valid_r;

  // DC blocker recurrence and output selection.
  always_comb begin
    dc_x_s      = DC_W'(scaled_s) <<< DC_SHIFT;
    dc_z_next_s = dc_x_s - dc_xprev_r + dc_z_r - (dc_z_r >>> DC_SHIFT);
    out_value_s = sat_word(64'(dc_z_r >>> DC_SHIFT));
    out_valid_s = dc_valid_r;
  end

  // DC blocker state, cleared with the rest of the filter.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      dc_xprev_r <= '0;
      dc_z_r     <= '0;
      dc_valid_r <= 1'b0;
    end else if (!enable_i) begin
      dc_xprev_r <= '0;
      dc_z_r     <= '0;
      dc_valid_r <= 1'b0;
    end else begin
      dc_valid_r <= comb_valid_r;
      if (comb_valid_r) begin
        dc_xprev_r <= dc_x_s;
        dc_z_r     <= dc_z_next_s;
      end
    end
  end
`else
  // Scaled comb output goes straight to saturation.
  always_comb begin
    out_value_s = sat_word(64'(scaled_s));
    out_valid_s = comb_valid_r;
  end
`endif

  // Capture state register.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r    <= IDLE;
      warm_cnt_r <= 2'd0;
    end else begin
      state_r    <= state_next_s;
      warm_cnt_r <= warm_cnt_next_s;
    end
  end

  // Next-state: warm-up swallows the first filter outputs, which are built
  // from an incomplete filter history.
  always_comb begin
    state_next_s    = state_r;
    warm_cnt_next_s = warm_cnt_r;
    case (state_r)
      IDLE: begin
        warm_cnt_next_s = 2'd0;
        if (enable_i) begin
          state_next_s = WARMUP;
        end else begin
          state_next_s = IDLE;
        end
      end
      WARMUP: begin
        if (!enable_i) begin
          state_next_s    = IDLE;
          warm_cnt_next_s = 2'd0;
        end else if (out_valid_s) begin
          if (warm_cnt_r == WARM_LAST) begin
            state_next_s    = RUN;
            warm_cnt_next_s = 2'd0;
          end else begin
            warm_cnt_next_s = warm_cnt_r + 2'd1;
          end
        end else begin
          state_next_s = WARMUP;
        end
      end
      RUN: begin
        if (!enable_i) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RUN;
        end
      end
      default: begin
        state_next_s    = IDLE;
        warm_cnt_next_s = 2'd0;
      end
    endcase
    emit_s = enable_i && (state_r == RUN) && out_valid_s;
  end

  // Output register: data_o only moves together with a done_o strobe.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      data_o <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= emit_s;
      if (emit_s) begin
        data_o <= out_value_s;
      end
    end
  end

endmodule
